instr_issuer: RTL
=================

INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction FIFO entries (power of 2).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles waited for any cpu_waiting transition.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  host pushes wr_data into FIFO.
REQ-006 wr_data  input  16  instruction word to queue.
REQ-007 full  output  1  FIFO holds DEPTH entries.
REQ-008 go  input  1  level enable; issuing occurs only while high.
REQ-009 cpu_instr  output  16  instruction presented to cpu.
REQ-010 cpu_load  output  1  cpu instruction-register load strobe.
REQ-011 cpu_start  output  1  cpu start strobe.
REQ-012 cpu_waiting  input  1  cpu idle/ready indication.
REQ-013 cpu_out  input  16  cpu datapath result.
REQ-014 cpu_N, cpu_V, cpu_Z  input  1 each  cpu status flags.
REQ-015 res_valid  output  1  one-cycle pulse, result captured.
REQ-016 res_data  output  16  captured cpu_out.
REQ-017 res_flags  output  3  captured {Z,V,N}.
REQ-018 done  output  1  FIFO empty and FSM in IDLE.
REQ-019 timeout  output  1  sticky error, cpu failed to respond.

Function
REQ-020 FSM states SHALL be IDLE, LAUNCH, ACK, BUSY, CAPTURE, ERR.
REQ-021 IDLE -> LAUNCH when go=1, FIFO non-empty, cpu_waiting=1; FIFO head popped into cpu_instr on that edge.
REQ-022 LAUNCH SHALL assert cpu_load=1 and cpu_start=1 for exactly one cycle, then enter ACK.
REQ-023 ACK -> BUSY when cpu_waiting=0; ACK -> ERR when cycle counter reaches TIMEOUT.
REQ-024 BUSY -> CAPTURE when cpu_waiting=1; BUSY -> ERR when counter reaches TIMEOUT.
REQ-025 Cycle counter SHALL clear on every state entry; saturates, no wrap.
REQ-026 CAPTURE SHALL register res_data<=cpu_out, res_flags<={cpu_Z,cpu_V,cpu_N}, pulse res_valid one cycle, return to IDLE.
REQ-027 res_data/res_flags SHALL hold until next CAPTURE.
REQ-028 cpu_instr SHALL stay stable from LAUNCH through CAPTURE.
REQ-029 ERR SHALL set timeout=1, hold cpu_load=cpu_start=0, leave only on rst.
REQ-030 Push when full SHALL be dropped, no state change; push when not full accepted any state.
REQ-031 Simultaneous push and pop SHALL keep count unchanged, including at full.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-033 go deasserted mid-instruction SHALL not abort; current instruction completes, no further pops.
REQ-034 done SHALL be combinational: FIFO empty and state IDLE.

Reset
REQ-035 rst=1 SHALL force IDLE from any state, including mid-BUSY, and empty FIFO.
REQ-036 Reset values: cpu_instr=0, cpu_load=0, cpu_start=0, res_valid=0, res_data=0, res_flags=0, timeout=0, full=0, done=1.

Structure
REQ-037 State enum and {Z,V,N} flag ordering SHALL live in shared package issuer_pkg.
REQ-038 FIFO SHALL be sub-module instr_fifo (16-bit, parameter DEPTH, full/empty/count).

Verification
REQ-039 Queue D007,D207,A2E6 with behavioural cpu model, go=1 -> three issues, third res_data=14, res_valid pulses per instruction.
REQ-040 Preload r3=4,r5=6, issue AB05 (CMP r3,r5) -> res_flags=3'b001, done=1 afterward.
REQ-041 cpu stub holding waiting=1 after start -> timeout=1 after 16 ACK cycles, no res_valid, state stuck until rst.
REQ-042 9 pushes with go=0 -> full=1 after 8th, 9th dropped; go=1 drains exactly 8 instructions.
REQ-043 At full, push and pop same cycle -> count stays 8, new word issued in order.
REQ-044 rst asserted during BUSY -> next cycle all outputs at reset values, done=1, FIFO empty.

Source files
------------

// File: rtl/issuer_pkg.sv
// Shared definitions for the instruction issuer: FSM encoding, word width
// and the packing order of the cpu status flags.
package issuer_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned FLAG_W = 3;

    // Bit positions inside res_flags, packed as {Z,V,N}
    localparam int unsigned FLAG_Z_BIT = 2;
    localparam int unsigned FLAG_V_BIT = 1;
    localparam int unsigned FLAG_N_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_ACK     = 3'd2,
        ST_BUSY    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_ERR     = 3'd5
    } issuer_state_e;

    // Single place that defines the {Z,V,N} ordering of captured flags
    function automatic logic [FLAG_W-1:0] pack_flags(input logic z, input logic v, input logic n);
        logic [FLAG_W-1:0] f;
        f             = 3'b000;
        f[FLAG_Z_BIT] = z;
        f[FLAG_V_BIT] = v;
        f[FLAG_N_BIT] = n;
        return f;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO. DEPTH must be a power of two (>= 2) so the read/write
// pointers wrap for free. A push while full is accepted only if a pop
// happens in the same cycle, which keeps the count at DEPTH.
module instr_fifo
    import issuer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [WORD_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_s;
    logic              pop_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign pop_s   = rd_en && !empty;
    assign push_s  = wr_en && (!full || pop_s);

    // Storage array; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: pops queued instruction words, hands them to the cpu
// with a load/start strobe, follows the cpu_waiting handshake and captures
// the result. A cpu that stops responding parks the block in ERR until reset.
module instr_issuer
    import issuer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic        full,
    input  logic        go,
    output logic [15:0] cpu_instr,
    output logic        cpu_load,
    output logic        cpu_start,
    input  logic        cpu_waiting,
    input  logic [15:0] cpu_out,
    input  logic        cpu_N,
    input  logic        cpu_V,
    input  logic        cpu_Z,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic [2:0]  res_flags,
    output logic        done,
    output logic        timeout
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    issuer_state_e     state_r;
    issuer_state_e     state_next_s;
    logic [TW-1:0]     wait_cnt_r;
    logic              cnt_hit_s;
    logic              launch_s;
    logic              pop_s;
    logic              load_next_s;
    logic              cap_next_s;
    logic              err_next_s;
    logic [WORD_W-1:0] fifo_head_s;
    logic              fifo_empty_s;
    logic [CW-1:0]     fifo_count_s;

    logic [15:0]       cpu_instr_r;
    logic              cpu_load_r;
    logic              cpu_start_r;
    logic              res_valid_r;
    logic [15:0]       res_data_r;
    logic [2:0]        res_flags_r;
    logic              timeout_r;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop_s),
        .rd_data (fifo_head_s),
        .full    (full),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign launch_s = go && !fifo_empty_s && cpu_waiting;
    // The edge that moves the counter from TIMEOUT-1 to TIMEOUT is the one
    // that leaves for ERR, so a stalled cpu gets exactly TIMEOUT cycles.
    assign cnt_hit_s = (wait_cnt_r == TW'(TIMEOUT - 1));

    assign cpu_instr = cpu_instr_r;
    assign cpu_load  = cpu_load_r;
    assign cpu_start = cpu_start_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_flags = res_flags_r;
    assign timeout   = timeout_r;
    assign done      = (fifo_count_s == {CW{1'b0}}) && (state_r == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; go is only looked at in IDLE so a started
    // instruction always runs to completion
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) state_next_s = ST_LAUNCH;
                else          state_next_s = ST_IDLE;
            end
            ST_LAUNCH:  state_next_s = ST_ACK;
            ST_ACK: begin
                if (!cpu_waiting)   state_next_s = ST_BUSY;
                else if (cnt_hit_s) state_next_s = ST_ERR;
                else                state_next_s = ST_ACK;
            end
            ST_BUSY: begin
                if (cpu_waiting)    state_next_s = ST_CAPTURE;
                else if (cnt_hit_s) state_next_s = ST_ERR;
                else                state_next_s = ST_BUSY;
            end
            ST_CAPTURE: state_next_s = ST_IDLE;
            ST_ERR:     state_next_s = ST_ERR;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Output decode, looking one state ahead so the strobes can be registered
    always_comb begin
        pop_s       = 1'b0;
        load_next_s = 1'b0;
        cap_next_s  = 1'b0;
        err_next_s  = 1'b0;
        case (state_next_s)
            ST_LAUNCH:  begin
                load_next_s = 1'b1;
                pop_s       = (state_r == ST_IDLE);
            end
            ST_CAPTURE: cap_next_s = 1'b1;
            ST_ERR:     err_next_s = 1'b1;
            default: begin
                pop_s       = 1'b0;
                load_next_s = 1'b0;
            end
        endcase
    end

    // Per-state wait counter: cleared on every state change, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (state_next_s != state_r) begin
            wait_cnt_r <= {TW{1'b0}};
        end else if (wait_cnt_r != TW'(TIMEOUT)) begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
        end
    end

    // Registered cpu-facing and result outputs; the result is sampled on the
    // edge entering CAPTURE so res_valid is high during CAPTURE itself
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_instr_r <= 16'h0000;
            cpu_load_r  <= 1'b0;
            cpu_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 16'h0000;
            res_flags_r <= 3'b000;
            timeout_r   <= 1'b0;
        end else begin
            cpu_load_r  <= load_next_s;
            cpu_start_r <= load_next_s;
            res_valid_r <= cap_next_s;
            timeout_r   <= timeout_r | err_next_s;
            if (pop_s) begin
                cpu_instr_r <= fifo_head_s;
            end
            if (cap_next_s) begin
                res_data_r  <= cpu_out;
                res_flags_r <= pack_flags(cpu_Z, cpu_V, cpu_N);
            end
        end
    end

endmodule
